// File: rtl/i2s_pcm_pkg.sv
// Shared constants, FSM state type and sample helper for the I2S PCM capture FIFO.
// Pure definitions, no latency; no flow control.
// Channel selection codes match the chan_sel register field.
package i2s_pcm_pkg;

    localparam int DEF_SAMPLE_W = 24;

    localparam logic [1:0] CH_LEFT   = 2'b00;
    localparam logic [1:0] CH_RIGHT  = 2'b01;
    localparam logic [1:0] CH_STEREO = 2'b10;
    localparam logic [1:0] CH_MONO   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PUSH1 = 2'b01,
        ST_PUSH2 = 2'b10
    } push_state_t;

    // Sign-extend the low w bits of raw to a full 32-bit word.
    function automatic logic [31:0] sext_sample(input logic [31:0] raw, input int w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = (i < w) ? raw[i] : raw[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with show-ahead head data and entry count.
// Latency: push visible at head one clk after the write edge; pop advances same edge.
// Backpressure: push accepted when not full or when a pop fires in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_fire;
    logic             pop_fire;

    assign empty     = (level == '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign pop_fire  = pop & ~empty;
    assign push_fire = push & (~full | pop_fire);
    assign pop_dat   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_pcm_fifo.sv
// Captures each I2S stereo frame, extracts/sign-extends PCM samples and buffers them on a valid/ready stream.
// Latency: first sample visible 2 clk after the ws rising edge is sampled; stereo R one clk later.
// Backpressure: m_ready drains the FIFO; frames that do not fit are dropped whole and set sticky ovf.
module i2s_pcm_fifo
    import i2s_pcm_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ws_i,
    input  logic [63:0]      rx_data_i,
    input  logic [1:0]       chan_sel,
    input  logic             bit_rev,
    input  logic [LVL_W-1:0] thresh,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [LVL_W-1:0] level,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             irq
);

    localparam logic [LVL_W:0] STEREO_MAX = (LVL_W+1)'(DEPTH - 2);

    push_state_t     state, state_nx;
    logic            ws_q;
    logic [63:0]     cap_q;
    logic [1:0]      mode_q;
    logic            rev_q;
    logic            fs, capture;
    logic            push, drop, full, empty, pop_fire, stereo_room;
    logic [31:0]     push_dat, samp_l, samp_r, samp_mono;
    logic [32:0]     mono_sum;
    logic [LVL_W:0]  used_after_pop;

    function automatic logic [31:0] extract(input logic [31:0] half, input logic rev);
        logic [31:0] raw;
        raw = '0;
        for (int k = 0; k < SAMPLE_W; k++) begin
            raw[k] = rev ? half[SAMPLE_W-1-k] : half[k];
        end
        return sext_sample(raw, SAMPLE_W);
    endfunction

    assign fs        = en & ws_i & ~ws_q;
    // The capture register is only free once the first word of the previous frame has been pushed.
    assign capture   = fs && (state != ST_PUSH1);
    assign m_valid   = ~empty;
    assign pop_fire  = m_valid & m_ready;
    assign samp_l    = extract(cap_q[63:32], rev_q);
    assign samp_r    = extract(cap_q[31:0], rev_q);
    assign mono_sum  = {samp_l[31], samp_l} + {samp_r[31], samp_r};
    assign samp_mono = mono_sum[32:1];
    assign used_after_pop = {1'b0, level} - {{LVL_W{1'b0}}, pop_fire};
    assign stereo_room    = (used_after_pop <= STEREO_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            ws_q   <= 1'b1;
            cap_q  <= '0;
            mode_q <= CH_LEFT;
            rev_q  <= 1'b0;
            ovf    <= 1'b0;
            irq    <= 1'b0;
        end else begin
            state <= state_nx;
            ws_q  <= ws_i;
            if (capture) begin
                cap_q  <= rx_data_i;
                mode_q <= chan_sel;
                rev_q  <= bit_rev;
            end
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            irq <= (thresh != '0) && (level >= thresh);
        end
    end

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        drop     = 1'b0;
        push_dat = samp_l;
        case (state)
            ST_IDLE: begin
                if (capture) state_nx = ST_PUSH1;
            end
            ST_PUSH1: begin
                state_nx = ST_IDLE;
                case (mode_q)
                    CH_RIGHT: push_dat = samp_r;
                    CH_MONO:  push_dat = samp_mono;
                    default:  push_dat = samp_l;
                endcase
                if (mode_q == CH_STEREO) begin
                    if (stereo_room) begin
                        push     = 1'b1;
                        state_nx = ST_PUSH2;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (full && !pop_fire) begin
                    drop = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            ST_PUSH2: begin
                push     = 1'b1;
                push_dat = samp_r;
                state_nx = capture ? ST_PUSH1 : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (m_ready),
        .pop_dat  (m_data),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

endmodule

// File: tb/tb_i2s_pcm_fifo.sv
// Scoreboard bench for i2s_pcm_fifo: stimulus queues expected words, a negedge monitor checks every handshake.
module tb_i2s_pcm_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ws_i;
    logic [63:0] rx_data_i;
    logic [1:0]  chan_sel;
    logic        bit_rev;
    logic [4:0]  thresh;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  level;
    logic        ovf;
    logic        ovf_clr;
    logic        irq;

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_d;

    always #5 clk = ~clk;

    i2s_pcm_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ws_i      (ws_i),
        .rx_data_i (rx_data_i),
        .chan_sel  (chan_sel),
        .bit_rev   (bit_rev),
        .thresh    (thresh),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .level     (level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .irq       (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ws low for one clk, then high with the frame word: the rising edge is captured at the next edge.
    task automatic send_frame(input logic [63:0] d);
        ws_i = 1'b0;
        tick();
        ws_i      = 1'b1;
        rx_data_i = d;
        tick();
    endtask

    function automatic logic [63:0] lframe(input logic [23:0] v);
        return {8'h00, v, 32'h0000_0000};
    endfunction

    task automatic drain();
        int n = 0;
        m_ready = 1'b1;
        while (m_valid && n < 64) begin
            tick();
            n++;
        end
        m_ready = 1'b0;
        chk("drain_empty", {31'b0, m_valid}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL pop_unexpected: got %h, required no word", m_data);
            end else begin
                exp_d = exp_q.pop_front();
                chk("pop_data", m_data, exp_d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; ws_i = 1'b1; rx_data_i = '0; chan_sel = 2'b00;
        bit_rev = 1'b0; thresh = '0; m_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_data",  m_data, 32'd0);
        chk("rst_level",   {27'b0, level}, 32'd0);
        chk("rst_ovf",     {31'b0, ovf}, 32'd0);
        chk("rst_irq",     {31'b0, irq}, 32'd0);

        // Left mode, junk in the unused upper byte of the half.
        send_frame({8'h5A, 24'h800001, 32'h1234_5678});
        chk("left_not_yet", {31'b0, m_valid}, 32'd0);
        tick();
        chk("left_valid", {31'b0, m_valid}, 32'd1);
        chk("left_data",  m_data, 32'hFF80_0001);
        chk("left_level", {27'b0, level}, 32'd1);
        exp_q.push_back(32'hFF80_0001);
        drain();

        // Stereo with bit reversal.
        chan_sel = 2'b10; bit_rev = 1'b1;
        send_frame({32'h0000_0001, 32'h0000_0002});
        tick(); tick();
        chk("stereo_level", {27'b0, level}, 32'd2);
        exp_q.push_back(32'hFF80_0000);
        exp_q.push_back(32'h0040_0000);
        drain();

        // Mono average, rounding toward -inf.
        chan_sel = 2'b11; bit_rev = 1'b0;
        send_frame({8'hAB, 24'h000004, 8'hCD, 24'hFFFFFE});
        tick();
        exp_q.push_back(32'h0000_0001);
        send_frame({8'h00, 24'hFFFFFF, 32'h0000_0000});
        tick();
        exp_q.push_back(32'hFFFF_FFFF);
        chk("mono_level", {27'b0, level}, 32'd2);
        drain();

        // Capture disabled: frame ignored.
        en = 1'b0; chan_sel = 2'b00;
        send_frame(lframe(24'h000042));
        tick(); tick();
        chk("en_off_level", {27'b0, level}, 32'd0);
        en = 1'b1;

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < 16; i++) begin
            send_frame(lframe(24'(100 + i)));
            tick();
            exp_q.push_back(32'(100 + i));
        end
        chk("full_level", {27'b0, level}, 32'd16);
        chk("full_no_ovf", {31'b0, ovf}, 32'd0);
        send_frame(lframe(24'h000077));
        tick();
        chk("ovf_level", {27'b0, level}, 32'd16);
        chk("ovf_set", {31'b0, ovf}, 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_clr", {31'b0, ovf}, 32'd0);

        // One free slot: a stereo frame is dropped whole.
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        chk("one_free_level", {27'b0, level}, 32'd15);
        chan_sel = 2'b10;
        send_frame({32'h0000_0011, 32'h0000_0022});
        tick(); tick();
        chk("stereo_drop_level", {27'b0, level}, 32'd15);
        chk("stereo_drop_ovf", {31'b0, ovf}, 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

        // Refill, then push while full with a simultaneous pop.
        chan_sel = 2'b00;
        send_frame(lframe(24'h000200));
        tick();
        exp_q.push_back(32'h0000_0200);
        chk("refill_level", {27'b0, level}, 32'd16);
        send_frame(lframe(24'h000201));
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        exp_q.push_back(32'h0000_0201);
        chk("full_pushpop_level", {27'b0, level}, 32'd16);
        chk("full_pushpop_ovf", {31'b0, ovf}, 32'd0);
        drain();

        // IRQ threshold.
        thresh = 5'd4;
        for (int i = 0; i < 3; i++) begin
            send_frame(lframe(24'(300 + i)));
            tick();
            exp_q.push_back(32'(300 + i));
        end
        tick();
        chk("irq_below", {31'b0, irq}, 32'd0);
        send_frame(lframe(24'd303));
        tick();
        exp_q.push_back(32'd303);
        tick();
        chk("irq_at_thresh", {31'b0, irq}, 32'd1);
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        tick();
        chk("irq_after_pop", {31'b0, irq}, 32'd0);
        drain();
        thresh = '0;

        // Reset while a stereo frame is in flight.
        chan_sel = 2'b10;
        send_frame({32'h0000_0033, 32'h0000_0044});
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_level", {27'b0, level}, 32'd0);
        repeat (4) tick();
        chk("midrst_level_later", {27'b0, level}, 32'd0);
        chk("midrst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("midrst_m_data", m_data, 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
